// File: rtl/mix_residual.sv
// Residual add after the 24x24 mix stage: captures mix output and skip matrix, adds one row per cycle with signed saturation.
// Latency: valid rises HID+1 edges after the accepting edge; no backpressure, run is ignored while CALC is in progress.
// Optional MIX_RES_RELU_EN clamps each saturated sum to zero when negative.

`ifndef HID_LENGTH
`define HID_LENGTH 24
`endif
`ifndef BIT_LENGTH
`define BIT_LENGTH 16
`endif
`ifndef STATE_LEN
`define STATE_LEN 4
`endif

module mix_residual #(
    parameter int                    HID       = `HID_LENGTH,
    parameter int                    BW        = `BIT_LENGTH,
    parameter logic [`STATE_LEN-1:0] ACT_STATE = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic [`STATE_LEN-1:0]   state,
    input  logic [HID*HID*BW-1:0]   data_in,
    input  logic [HID*HID*BW-1:0]   skip_in,
    output logic                    valid,
    output logic [HID*HID*BW-1:0]   data_out
);

    localparam int            CW   = (HID > 1) ? $clog2(HID) : 1;
    localparam int            RW   = HID * BW;
    localparam logic [CW-1:0] LAST = CW'(HID - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} fsm_t;

    fsm_t                  fsm_q;
    logic [CW-1:0]         row_cnt_q;
    logic                  valid_q;
    logic [HID*HID*BW-1:0] a_q;
    logic [HID*HID*BW-1:0] b_q;
    logic [HID*HID*BW-1:0] out_q;
    logic [RW-1:0]         a_row;
    logic [RW-1:0]         b_row;
    logic [RW-1:0]         row_d;
    logic                  accept;

    function automatic logic [BW-1:0] sat_add(input logic [BW-1:0] x, input logic [BW-1:0] y);
        logic [BW:0]   s;
        logic [BW-1:0] r;
        s = {x[BW-1], x} + {y[BW-1], y};
        // Sign and guard bit disagree only when the true sum left the BW-bit range.
        if (s[BW] != s[BW-1]) begin
            r = s[BW] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
        end else begin
            r = s[BW-1:0];
        end
`ifdef MIX_RES_RELU_EN
        if (r[BW-1]) begin
            r = '0;
        end
`endif
        return r;
    endfunction

    assign accept = run && (state == ACT_STATE) && (fsm_q != CALC);

    always_comb begin
        a_row = a_q[int'(row_cnt_q)*RW +: RW];
        b_row = b_q[int'(row_cnt_q)*RW +: RW];
        row_d = '0;
        for (int c = 0; c < HID; c++) begin
            row_d[c*BW +: BW] = sat_add(a_row[c*BW +: BW], b_row[c*BW +: BW]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            row_cnt_q <= '0;
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            out_q     <= '0;
        end else if (accept) begin
            a_q       <= data_in;
            b_q       <= skip_in;
            valid_q   <= 1'b0;
            row_cnt_q <= '0;
            fsm_q     <= CALC;
        end else begin
            case (fsm_q)
                CALC: begin
                    out_q[int'(row_cnt_q)*RW +: RW] <= row_d;
                    if (row_cnt_q == LAST) begin
                        row_cnt_q <= '0;
                        fsm_q     <= DONE;
                    end else begin
                        row_cnt_q <= row_cnt_q + 1'b1;
                    end
                end
                DONE:    valid_q <= 1'b1;
                default: fsm_q   <= IDLE;
            endcase
        end
    end

    assign valid    = valid_q;
    assign data_out = out_q;

endmodule

// File: tb/tb_mix_residual.sv
// Directed bench for mix_residual: timing/arith model checked every cycle plus literal spot checks.

`ifndef STATE_LEN
`define STATE_LEN 4
`endif

module tb_mix_residual;

    localparam int HID = 24;
    localparam int BW  = 16;
    localparam int N   = HID * HID * BW;
    localparam logic [`STATE_LEN-1:0] ACT = '0;

    logic                  clk;
    logic                  rst_n;
    logic                  run;
    logic [`STATE_LEN-1:0] state;
    logic [N-1:0]          data_in;
    logic [N-1:0]          skip_in;
    logic                  valid;
    logic [N-1:0]          data_out;

    int n_cmp  = 0;
    int n_fail = 0;

    mix_residual dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .state    (state),
        .data_in  (data_in),
        .skip_in  (skip_in),
        .valid    (valid),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: element-wise wide integer add, clamped to the signed BW range.
    function automatic logic [N-1:0] model_res(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] r;
        int s;
        r = '0;
        for (int i = 0; i < HID*HID; i++) begin
            s = int'($signed(a[i*BW +: BW])) + int'($signed(b[i*BW +: BW]));
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
`ifdef MIX_RES_RELU_EN
            if (s < 0) s = 0;
`endif
            r[i*BW +: BW] = s[BW-1:0];
        end
        return r;
    endfunction

    function automatic logic [15:0] el(input logic [N-1:0] v, input int r, input int c);
        return v[(r*HID + c)*BW +: BW];
    endfunction

    // Timing model: edges elapsed since the last accepted run.
    logic         m_active = 1'b0;
    int           m_since  = 0;
    logic [N-1:0] exp_out  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_since  = 0;
        end else if (run && state == ACT && (!m_active || m_since >= HID)) begin
            m_active = 1'b1;
            m_since  = 0;
            exp_out  = model_res(data_in, skip_in);
        end else if (m_active && m_since < 1000) begin
            m_since++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            for (int i = 0; i < HID*HID; i++) begin
                if (act[i*BW +: BW] !== exp[i*BW +: BW]) begin
                    $display("FAIL %s: element (%0d,%0d) got %0h expected %0h at %0t",
                             nm, i / HID, i % HID, act[i*BW +: BW], exp[i*BW +: BW], $time);
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin : cmp
        logic exp_v;
        exp_v = m_active && (m_since >= HID + 1);
        chk("valid_cyc", {31'b0, valid}, {31'b0, exp_v});
        if (exp_v) chk_vec("data_cyc", data_out, exp_out);
    end

    task automatic fill(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < HID*HID; i++) begin
            data_in[i*BW +: BW] = a;
            skip_in[i*BW +: BW] = b;
        end
    endtask

    task automatic setel(input int r, input int c, input logic [15:0] a, input logic [15:0] b);
        data_in[(r*HID + c)*BW +: BW] = a;
        skip_in[(r*HID + c)*BW +: BW] = b;
    endtask

    task automatic do_run();
        run   = 1'b1;
        state = ACT;
        @(posedge clk);
        #1 run = 1'b0;
    endtask

    // Returns the edge number (counted after the accept edge) on which valid rose; 0 on timeout.
    task automatic wait_valid(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                n = i;
                break;
            end
        end
    endtask

    int n;

    initial begin
        rst_n   = 1'b0;
        run     = 1'b0;
        state   = ACT;
        data_in = '0;
        skip_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk_vec("rst_data", data_out, '0);
        rst_n = 1'b1;

        // run with the wrong layer state is ignored
        fill(16'h0003, 16'h0005);
        state = 4'd3;
        run   = 1'b1;
        repeat (3) @(posedge clk);
        #1 run = 1'b0;
        state = ACT;
        repeat (30) @(posedge clk);
        #1;
        chk("gated_valid", {31'b0, valid}, 32'd0);

        // basic add
        do_run();
        wait_valid(n);
        chk("lat_basic", n, 32'd25);
        chk("basic_00", el(data_out, 0, 0), 32'h0008);
        chk("basic_2323", el(data_out, 23, 23), 32'h0008);
        repeat (5) @(posedge clk);
        #1;
        chk("basic_hold", {31'b0, valid}, 32'd1);

        // saturation, late run pulse, input change after accept
        fill(16'h0000, 16'h0000);
        setel(0, 0, 16'h7000, 16'h2000);
        setel(23, 23, 16'h8000, 16'hFFFF);
        setel(5, 7, 16'hFFF0, 16'h0008);
        do_run();
        data_in = '1;
        repeat (9) @(posedge clk);
        #1 run = 1'b1;
        @(posedge clk);
        #1 run = 1'b0;
        wait_valid(n);
        chk("lat_ignore", n + 10, 32'd25);
        chk("sat_pos", el(data_out, 0, 0), 32'h7FFF);
`ifdef MIX_RES_RELU_EN
        chk("sat_neg", el(data_out, 23, 23), 32'h0000);
        chk("neg_57", el(data_out, 5, 7), 32'h0000);
`else
        chk("sat_neg", el(data_out, 23, 23), 32'h8000);
        chk("neg_57", el(data_out, 5, 7), 32'hFFF8);
`endif
        chk("zero_11", el(data_out, 1, 1), 32'h0000);

        // back-to-back run from DONE
        fill(16'h0001, 16'h0001);
        do_run();
        chk("b2b_fall", {31'b0, valid}, 32'd0);
        wait_valid(n);
        chk("lat_b2b", n, 32'd25);
        chk("b2b_00", el(data_out, 0, 0), 32'h0002);
        chk("b2b_1222", el(data_out, 12, 22), 32'h0002);

        // row/column layout
        skip_in = '0;
        for (int r = 0; r < HID; r++)
            for (int c = 0; c < HID; c++)
                data_in[(r*HID + c)*BW +: BW] = 16'(r*HID + c);
        do_run();
        wait_valid(n);
        chk("lat_layout", n, 32'd25);
        chk_vec("layout", data_out, data_in);
        chk("layout_10", el(data_out, 1, 0), 32'd24);
        chk("layout_2323", el(data_out, 23, 23), 32'd575);

        // reset in the middle of CALC
        fill(16'h0007, 16'h0009);
        do_run();
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'b0, valid}, 32'd0);
        chk_vec("mid_rst_data", data_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("post_rst_idle", {31'b0, valid}, 32'd0);
        do_run();
        wait_valid(n);
        chk("lat_post_rst", n, 32'd25);
        chk("post_rst_val", el(data_out, 12, 3), 32'h0010);

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
